// File: rtl/cal_atan2.sv
// cal_atan2 -- CORDIC vectoring-mode atan2 with optional magnitude output.
//
// Converts a signed 2.12 (x, y) operand pair into an angle on the same
// 4.8 scale as the cal_sin/cal_cos angle input, where 2pi = 0x648.
// The result lies in [0x000, 0x647].
//
// Optional feature: define CAL_ATAN2_MAG_EN to compute mag_out.
// mag_out is then the final CORDIC x scaled by the gain compensation.
// With the macro undefined, mag_out is tied to zero and no multiplier
// is built.
//
// Handshake: an input transfer happens on a rising edge where in_valid
// and in_ready are both high. An output transfer happens on a rising
// edge where out_valid and out_ready are both high. in_ready is high only
// in IDLE. out_valid is high only in DONE. angle_out and mag_out stay
// constant while out_valid waits for out_ready.
//
// Latency: count the accepting edge as edge 1. The block then walks
// through PREP, ITER x ITER cycles and POST. out_valid rises after edge
// ITER+3.

module cal_atan2 #(
  parameter int ITER = 12
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] x_in,
  input  logic [13:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] angle_out,
  output logic [13:0] mag_out
);

  // pi in the 4.16 accumulator format (3.14159 * 65536 = 0x3243F).
  localparam logic signed [19:0] Z_PI     = 20'sh3243F;
  // 2pi on the 4.8 output scale.
  localparam logic signed [19:0] TWO_PI_Q8 = 20'sd1608;
  localparam logic [3:0]         CNT_LAST = 4'(ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_POST,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [13:0]        r_x_cap;
  logic [13:0]        r_y_cap;
  logic               r_zero;
  logic signed [17:0] r_x;
  logic signed [17:0] r_y;
  logic signed [19:0] r_z;
  logic [3:0]         r_cnt;
  logic [11:0]        r_angle;

  logic signed [17:0] w_x_ext;
  logic signed [17:0] w_y_ext;
  logic signed [17:0] w_x_sh;
  logic signed [17:0] w_y_sh;
  logic signed [19:0] w_atan;
  logic signed [19:0] w_z_rnd;
  logic signed [19:0] w_z_wrap;
  logic [11:0]        w_angle;

  // atan(2^-i) in 4.16, rounded to nearest. Entries 14 and 15 are never used.
  function automatic logic signed [19:0] atan_lut(input logic [3:0] idx);
    logic signed [19:0] v;
    case (idx)
      4'd0:    v = 20'sd51472;
      4'd1:    v = 20'sd30386;
      4'd2:    v = 20'sd16055;
      4'd3:    v = 20'sd8150;
      4'd4:    v = 20'sd4091;
      4'd5:    v = 20'sd2047;
      4'd6:    v = 20'sd1024;
      4'd7:    v = 20'sd512;
      4'd8:    v = 20'sd256;
      4'd9:    v = 20'sd128;
      4'd10:   v = 20'sd64;
      4'd11:   v = 20'sd32;
      4'd12:   v = 20'sd16;
      4'd13:   v = 20'sd8;
      default: v = 20'sd0;
    endcase
    return v;
  endfunction

  assign w_x_ext = {{4{r_x_cap[13]}}, r_x_cap};
  assign w_y_ext = {{4{r_y_cap[13]}}, r_y_cap};
  assign w_x_sh  = r_x >>> r_cnt;
  assign w_y_sh  = r_y >>> r_cnt;
  assign w_atan  = atan_lut(r_cnt);

  // Round z half-up to 8 fractional bits, then fold it into [0, 2pi).
  always_comb begin
    w_z_rnd = (r_z + 20'sd128) >>> 8;
    if (w_z_rnd < 20'sd0) begin
      w_z_wrap = w_z_rnd + TWO_PI_Q8;
    end else if (w_z_rnd >= TWO_PI_Q8) begin
      w_z_wrap = w_z_rnd - TWO_PI_Q8;
    end else begin
      w_z_wrap = w_z_rnd;
    end
    // A zero vector has no defined angle.
    // The iterations would drift z toward +1.74 rad, so report 0.
    w_angle = r_zero ? 12'h000 : 12'(w_z_wrap);
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_PREP;
      end
      S_PREP: w_state_nxt = S_ITER;
      S_ITER: begin
        if (r_cnt == CNT_LAST) w_state_nxt = S_POST;
      end
      S_POST: w_state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, pre-rotation, CORDIC micro-rotations and angle result.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_x_cap <= 14'h0;
      r_y_cap <= 14'h0;
      r_zero  <= 1'b0;
      r_x     <= 18'sd0;
      r_y     <= 18'sd0;
      r_z     <= 20'sd0;
      r_cnt   <= 4'd0;
      r_angle <= 12'h000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x_cap <= x_in;
            r_y_cap <= y_in;
            r_zero  <= (x_in == 14'h0) && (y_in == 14'h0);
          end
        end
        S_PREP: begin
          r_cnt <= 4'd0;
          // Left half-plane: rotate by pi so the CORDIC range covers it.
          if (r_x_cap[13]) begin
            r_x <= -w_x_ext;
            r_y <= -w_y_ext;
            r_z <= Z_PI;
          end else begin
            r_x <= w_x_ext;
            r_y <= w_y_ext;
            r_z <= 20'sd0;
          end
        end
        S_ITER: begin
          if (!r_y[17]) begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan;
          end
          if (r_cnt == CNT_LAST) begin
            r_cnt <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_POST: r_angle <= w_angle;
        default: ;
      endcase
    end
  end

  assign angle_out = r_angle;

`ifdef CAL_ATAN2_MAG_EN
  logic [13:0]        r_mag;
  logic signed [31:0] w_mag_prod;
  logic signed [31:0] w_mag_rnd;
  logic [13:0]        w_mag_sat;

  // Scale the final x by 0x9B7 (0.6073), round to 2.12 and saturate.
  always_comb begin
    w_mag_prod = 32'(r_x) * 32'sd2487;
    w_mag_rnd  = (w_mag_prod + 32'sd2048) >>> 12;
    if (r_zero || (w_mag_rnd < 32'sd0)) begin
      w_mag_sat = 14'h0000;
    end else if (w_mag_rnd > 32'sd16383) begin
      w_mag_sat = 14'h3FFF;
    end else begin
      w_mag_sat = 14'(w_mag_rnd);
    end
  end

  // Magnitude result register, loaded together with the angle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mag <= 14'h0000;
    end else if (r_state == S_POST) begin
      r_mag <= w_mag_sat;
    end
  end

  assign mag_out = r_mag;
`else
  assign mag_out = 14'h0000;
`endif

endmodule

// File: doc/cal_atan2.md
CAL_ATAN2 -- requirements
Module: cal_atan2

Interface
REQ-001 SHALL have parameter ITER, default 12, number of CORDIC vectoring iterations (legal 8..14).
REQ-002 SHALL have port Clk, input, 1, sole clock, all state on rising edge.
REQ-003 SHALL have port Reset_n, input, 1. Reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning x_in/y_in are valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept an operand pair.
REQ-006 SHALL have port x_in, input, 14, signed 2.12 cosine-domain operand.
REQ-007 SHALL have port y_in, input, 14, signed 2.12 sine-domain operand.
REQ-008 SHALL have port out_valid, output, 1, meaning angle_out/mag_out are valid.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-010 SHALL have port angle_out, output, 12, unsigned 4.8 angle in [0x000, 0x647], same format as the cal_sin/cal_cos angle input.
REQ-011 SHALL have port mag_out, output, 14, unsigned 2.12 magnitude.

Function
REQ-012 SHALL compute angle_out = atan2(y_in, x_in) mapped to [0, 2pi), with 2pi = 0x648, pi = 0x324, pi/2 = 0x192 and 3pi/2 = 0x4b6.
REQ-013 SHALL implement an FSM with states IDLE, PREP, ITER, POST and DONE.
- IDLE: in_ready=1; on in_valid go to PREP and capture the operands.
- PREP: 1 cycle.
- ITER: ITER cycles.
- POST: 1 cycle.
- DONE: out_valid=1; on out_ready go to IDLE.
REQ-014 SHALL deassert in_ready in every state except IDLE, and SHALL ignore in_valid outside IDLE.
REQ-015 SHALL, in PREP, sign-extend x and y to 18-bit signed working registers.
- If x < 0: negate both, set the angle accumulator z to pi.
- Otherwise: set z to 0.
REQ-016 SHALL hold z as signed 20-bit with 16 fractional bits.
REQ-017 SHALL use a constant table atan(2^-i), i=0..ITER-1, in 4.16 format, with each entry rounded to nearest.
REQ-018 SHALL, on ITER step i, apply the vectoring rule using arithmetic right shifts:
- if y >= 0: x += y>>>i, y -= x>>>i, z += atan_i;
- else: x -= y>>>i, y += x>>>i, z -= atan_i.
REQ-019 SHALL use an iteration counter that runs 0..ITER-1 and clears on leaving ITER.
REQ-020 SHALL, in POST, round z to 8 fractional bits (round half up).
- Add 0x648 if the result is negative.
- Subtract 0x648 if the result is >= 0x648.
- Register the result to angle_out.
REQ-021 SHALL give angle_out = 0x000 and mag_out = 0 for x_in = y_in = 0.
REQ-022 SHALL assert out_valid exactly ITER+3 rising edges after the accepting edge (in_valid and in_ready both high).
REQ-023 SHALL hold angle_out and mag_out stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-024 SHALL allow in_ready to be asserted no earlier than the cycle after the DONE handshake; there are no back-to-back overlapping operations.
REQ-025 SHALL handle the operand extremes (0x2000 = -2.0, 0x1FFF) without overflow in the 18-bit working registers.

Reset
REQ-026 SHALL, on Reset_n low, asynchronously force:
- state = IDLE;
- in_ready = 1 once the FSM is in IDLE;
- out_valid = 0;
- angle_out = 0x000;
- mag_out = 0;
- counter = 0;
- x, y and z = 0.
REQ-027 SHALL abandon any operation in progress when reset asserts mid-operation, and SHALL produce no out_valid for it after release.
REQ-028 SHALL leave IDLE no earlier than the first rising edge after Reset_n deassertion.

Configuration
REQ-029 SHALL, when macro CAL_ATAN2_MAG_EN is defined, compute mag_out in POST:
- multiply the final x by the CORDIC gain compensation 0x09B7 (0.6073 in 0.12 format);
- round to 2.12;
- saturate to 0x3FFF.
REQ-030 SHALL, when CAL_ATAN2_MAG_EN is undefined:
- drive mag_out constant 0;
- synthesize no multiplier;
- leave angle behaviour and latency unchanged.

Verification
REQ-031 SHALL verify: x=0x1000, y=0x0000 -> angle_out=0x000 (±1 LSB), mag_out=0x1000 (±2 LSB with CAL_ATAN2_MAG_EN).
REQ-032 SHALL verify the axis cases:
- x=0x0000, y=0x1000 -> 0x192;
- x=0x3000 (-1.0), y=0x0000 -> 0x324;
- x=0x0000, y=0x3000 -> 0x4b6;
- each within ±1 LSB.
REQ-033 SHALL verify a round trip: sweep angle 0x000..0x647 through cal_cos/cal_sin into x_in/y_in -> angle_out within ±2 LSB of the input angle, including wrap near 0x647 -> 0x000.
REQ-034 SHALL verify x=y=0 -> angle_out=0x000, mag_out=0, out_valid at exactly ITER+3 edges after accept.
REQ-035 SHALL verify backpressure: hold out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0; then out_ready=1 -> in_ready=1 on the next cycle.
REQ-036 SHALL verify mid-operation reset: pulse Reset_n low during ITER -> out_valid=0 and all outputs zero immediately; the next operation completes correctly.
